// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   state_e      : controller FSM encoding (IDLE=0, ACCESS=1, RESP=2)
//   lat_init()   : preload value for the bus-hold counter
//   LAT_CNT_W    : width of the bus-hold counter
package dmem_access_ctrl_pkg;

  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // The counter runs from MEM_LAT-1 down to 0, so ACCESS lasts MEM_LAT cycles.
  // Legal MEM_LAT is 1..15 to fit the 4-bit counter.
  function automatic logic [LAT_CNT_W-1:0] lat_init(input int unsigned mem_lat);
    return LAT_CNT_W'(mem_lat - 1);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Initiator side of the data-memory interface in the CPU memory stage. Takes
// one load/store at a time from the pipeline, drives the memory bus for
// MEM_LAT cycles, captures the read data / error and returns one response.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake from the pipeline
//   req_write, req_addr,        request: store flag, word address, store data
//   req_wdata
//   resp_valid/resp_ready       response handshake to the pipeline
//   resp_data, resp_error       load data (0 for stores/faults), address fault
//   mem_addr, mem_wdata         memory bus address / write data (registered)
//   mem_write_flag,             memory strobes, mutually exclusive, idle low
//   mem_read_flag
//   mem_rdata, mem_error        memory read data and fault from the memory
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DATA_WID = 64,
  parameter int MAX_ADDR = 10,
  parameter int MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [DATA_WID-1:0] req_addr,
  input  logic [DATA_WID-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_WID-1:0] resp_data,
  output logic                resp_error,
  output logic [DATA_WID-1:0] mem_addr,
  output logic [DATA_WID-1:0] mem_wdata,
  output logic                mem_write_flag,
  output logic                mem_read_flag,
  input  logic [DATA_WID-1:0] mem_rdata,
  input  logic                mem_error
);

  localparam logic [DATA_WID-1:0]  MAX_ADDR_W = DATA_WID'(MAX_ADDR);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD   = lat_init(MEM_LAT);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [LAT_CNT_W-1:0]   r_lat_cnt;
  logic [DATA_WID-1:0]    r_addr;
  logic [DATA_WID-1:0]    r_wdata;
  logic                   r_write;
  logic [DATA_WID-1:0]    r_resp_data;
  logic                   r_resp_error;
  logic                   w_addr_ok;
  logic                   w_lat_done;

  // Full-width unsigned compare: high address bits must not alias into range.
  assign w_addr_ok  = (req_addr <= MAX_ADDR_W);
  assign w_lat_done = (r_lat_cnt == '0);

  // Next-state and output decode
  always_comb begin
    w_next_state   = r_state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_write_flag = 1'b0;
    mem_read_flag  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next_state = w_addr_ok ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        mem_write_flag = r_write;
        mem_read_flag  = ~r_write;
        if (w_lat_done) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        // Back to IDLE only; the next request is taken a cycle later.
        if (resp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State, bus and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_write      <= 1'b0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_addr_ok) begin
              r_addr    <= req_addr;
              r_wdata   <= req_wdata;
              r_write   <= req_write;
              r_lat_cnt <= LAT_LOAD;
            end else begin
              // Faulting address: bus registers are left untouched.
              r_resp_data  <= '0;
              r_resp_error <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (w_lat_done) begin
            r_resp_data  <= r_write ? '0 : mem_rdata;
            r_resp_error <= mem_error;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign resp_data  = r_resp_data;
  assign resp_error = r_resp_error;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: dut0 (MEM_LAT=1) against a small memory model,
// dut1 (MEM_LAT=3) for longer latency and mid-access reset.
module tb_dmem_access_ctrl;

  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0 signals
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [DW-1:0] req_addr, req_wdata;
  logic          resp_valid, resp_ready, resp_error;
  logic [DW-1:0] resp_data, mem_addr, mem_wdata, mem_rdata;
  logic          mem_write_flag, mem_read_flag, mem_error;

  // dut1 signals
  logic          rst1_n;
  logic          req1_valid, req1_ready, req1_write;
  logic [DW-1:0] req1_addr, req1_wdata;
  logic          resp1_valid, resp1_ready, resp1_error;
  logic [DW-1:0] resp1_data, mem1_addr, mem1_wdata, mem1_rdata;
  logic          mem1_write_flag, mem1_read_flag, mem1_error;

  dmem_access_ctrl #(.DATA_WID(DW), .MAX_ADDR(10), .MEM_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_error(resp_error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write_flag(mem_write_flag), .mem_read_flag(mem_read_flag),
    .mem_rdata(mem_rdata), .mem_error(mem_error)
  );

  dmem_access_ctrl #(.DATA_WID(DW), .MAX_ADDR(10), .MEM_LAT(3)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .req_valid(req1_valid), .req_ready(req1_ready), .req_write(req1_write),
    .req_addr(req1_addr), .req_wdata(req1_wdata),
    .resp_valid(resp1_valid), .resp_ready(resp1_ready),
    .resp_data(resp1_data), .resp_error(resp1_error),
    .mem_addr(mem1_addr), .mem_wdata(mem1_wdata),
    .mem_write_flag(mem1_write_flag), .mem_read_flag(mem1_read_flag),
    .mem_rdata(mem1_rdata), .mem_error(mem1_error)
  );

  // Memory model for dut0: 16 words, optional injected fault on reads.
  logic [DW-1:0] mem [0:15];
  logic          inj_err;
  always @(posedge clk) if (mem_write_flag) mem[mem_addr[3:0]] <= mem_wdata;
  assign mem_rdata  = (mem_read_flag && !inj_err) ? mem[mem_addr[3:0]] : '0;
  assign mem_error  = mem_read_flag && inj_err;
  // dut1 memory: constant word, only visible while the read strobe is high.
  assign mem1_rdata = mem1_read_flag ? 64'h1234 : '0;
  assign mem1_error = 1'b0;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acc_cyc;
    int            lat;
    string         name;
  } exp_t;
  exp_t sb[$];

  // Monitor for dut0: response contents, first-visible latency, stability
  // while stalled, and bus strobe accounting.
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
  initial begin
    logic          prev_v;
    logic [DW-1:0] held_d;
    logic          held_e;
    int            first_cyc, unstable, rdy_in_resp;
    exp_t          e;
    prev_v = 1'b0; held_d = '0; held_e = 1'b0;
    first_cyc = 0; unstable = 0; rdy_in_resp = 0;
    forever begin
      @(negedge clk);
      if (mem_write_flag) wr_cnt++;
      if (mem_read_flag) rd_cnt++;
      if (mem_write_flag && mem_read_flag) both_cnt++;
      if (resp_valid && !prev_v) begin
        first_cyc = cyc; held_d = resp_data; held_e = resp_error;
        unstable = 0; rdy_in_resp = 0;
      end else if (resp_valid) begin
        if (resp_data !== held_d || resp_error !== held_e) unstable++;
      end
      if (resp_valid && req_ready) rdy_in_resp++;
      if (resp_valid && resp_ready && rst_n) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_resp: got response data 0x%0h with nothing outstanding", resp_data);
        end else begin
          e = sb.pop_front();
          check({e.name, "_data"}, resp_data, e.data);
          check({e.name, "_err"}, DW'(resp_error), DW'(e.err));
          check({e.name, "_lat"}, DW'(first_cyc - e.acc_cyc), DW'(e.lat));
          check({e.name, "_stable"}, DW'(unstable), 0);
          check({e.name, "_noaccept"}, DW'(rdy_in_resp), 0);
        end
      end
      prev_v = resp_valid;
    end
  end

  int last_acc = 0;

  // Issue one request to dut0 and queue its expected response.
  // lat = cycles from the accept cycle to the first cycle resp_valid is seen.
  task automatic issue(input logic wr, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] exp_d, input logic exp_e, input int lat,
                       input string name);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 40);
    if (!req_ready) begin
      total++;
      $display("FAIL %s_accept: req_ready stayed 0 for %0d cycles, required 1", name, n);
      req_valid = 1'b0;
      return;
    end
    last_acc  = cyc;
    e.data    = exp_d; e.err = exp_e; e.acc_cyc = cyc; e.lat = lat; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL %s_drain: %0d responses still outstanding, required 0", name, sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int w0, r0, rel_cyc, acc, n, rdc, seen;
    rst_n = 1'b0; rst1_n = 1'b0; inj_err = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; resp1_ready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", DW'(req_ready), 1);
    check("rst_resp_valid", DW'(resp_valid), 0);
    check("rst_flags", DW'({mem_write_flag, mem_read_flag}), 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_error", DW'(resp_error), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1; rst_n = 1'b1; rst1_n = 1'b1;

    // Store 0xAB to address 3
    w0 = wr_cnt; r0 = rd_cnt;
    issue(1'b1, 3, 64'hAB, 0, 1'b0, 2, "st3");
    check("st3_wflag", DW'(mem_write_flag), 1);
    check("st3_rflag", DW'(mem_read_flag), 0);
    check("st3_bus_addr", mem_addr, 3);
    check("st3_bus_wdata", mem_wdata, 64'hAB);
    drain("st3");
    check("st3_wflag_cycles", DW'(wr_cnt - w0), 1);
    check("st3_rflag_cycles", DW'(rd_cnt - r0), 0);

    // Load it back
    w0 = wr_cnt; r0 = rd_cnt;
    issue(1'b0, 3, 0, 64'hAB, 1'b0, 2, "ld3");
    check("ld3_rflag", DW'(mem_read_flag), 1);
    check("ld3_bus_addr", mem_addr, 3);
    drain("ld3");
    check("ld3_rflag_cycles", DW'(rd_cnt - r0), 1);
    check("ld3_wflag_cycles", DW'(wr_cnt - w0), 0);

    // Out-of-range load: bus untouched, fault response next cycle
    w0 = wr_cnt; r0 = rd_cnt;
    issue(1'b0, 11, 0, 0, 1'b1, 1, "ld11");
    check("ld11_bus_addr_kept", mem_addr, 3);
    drain("ld11");
    check("ld11_no_flags", DW'((wr_cnt - w0) + (rd_cnt - r0)), 0);

    // Highest legal address, and a high-bit address that would alias to 3
    issue(1'b1, 10, 64'h5555_0000_0000_00CC, 0, 1'b0, 2, "st10");
    drain("st10");
    issue(1'b0, 10, 0, 64'h5555_0000_0000_00CC, 1'b0, 2, "ld10");
    drain("ld10");
    r0 = rd_cnt;
    issue(1'b0, 64'h8000_0000_0000_0003, 0, 0, 1'b1, 1, "ld_hi");
    drain("ld_hi");
    check("ld_hi_no_read", DW'(rd_cnt - r0), 0);

    // Memory-side fault on a legal load
    inj_err = 1'b1;
    issue(1'b0, 3, 0, 0, 1'b1, 2, "ld_memerr");
    drain("ld_memerr");
    inj_err = 1'b0;

    // Stalled response with a second request already waiting
    resp_ready = 1'b0;
    issue(1'b0, 3, 0, 64'hAB, 1'b0, 2, "ld_hold");
    fork
      issue(1'b0, 10, 0, 64'h5555_0000_0000_00CC, 1'b0, 2, "ld_after");
    join_none
    repeat (6) @(posedge clk);
    #1;
    check("hold_resp_valid", DW'(resp_valid), 1);
    check("hold_req_ready", DW'(req_ready), 0);
    check("hold_resp_data", resp_data, 64'hAB);
    rel_cyc = cyc;
    resp_ready = 1'b1;
    wait fork;
    drain("hold");
    check("hold_accept_cycle", DW'(last_acc - rel_cyc), 1);

    check("no_both_flags", DW'(both_cnt), 0);

    // dut1, MEM_LAT=3: read strobe lasts 3 cycles, response on the 4th
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 2;
    @(negedge clk);
    check("l3_req_ready", DW'(req1_ready), 1);
    acc = cyc;
    @(posedge clk); #1; req1_valid = 1'b0;
    n = 0; rdc = 0;
    while (!resp1_valid && n < 20) begin
      @(negedge clk); n++;
      if (mem1_read_flag) rdc++;
    end
    check("l3_rflag_cycles", DW'(rdc), 3);
    check("l3_lat", DW'(cyc - acc), 4);
    check("l3_data", resp1_data, 64'h1234);
    check("l3_err", DW'(resp1_error), 0);

    // dut1: reset in the middle of ACCESS drops the access
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 4;
    @(negedge clk);
    @(posedge clk); #1; req1_valid = 1'b0;
    @(negedge clk);
    check("midrst_rflag_before", DW'(mem1_read_flag), 1);
    #1 rst1_n = 1'b0;
    #1;
    check("midrst_flags", DW'({mem1_write_flag, mem1_read_flag}), 0);
    check("midrst_req_ready", DW'(req1_ready), 1);
    check("midrst_resp_valid", DW'(resp1_valid), 0);
    @(posedge clk); #1; rst1_n = 1'b1;
    seen = 0;
    repeat (8) begin @(negedge clk); if (resp1_valid) seen++; end
    check("midrst_no_resp", DW'(seen), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d checks so far", passed, total);
    $fatal(1, "timeout");
  end

endmodule
